conversor_binario_bcd: RTL and testbench

CONVERSOR_BINARIO_BCD -- requirements
Module: conversor_binario_bcd

---
 rtl/conversor_binario_bcd.sv | 98 +++++++++
 tb/tb_conversor_binario_bcd.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conversor_binario_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conversor_binario_bcd: sequential binary-to-BCD converter (double dabble), |
// | one bit per clock, WIDTH cycles per conversion.  Rev 1.0                   |
// +----------------------------------------------------------------------------+
module conversor_binario_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                inicio,
  input  logic [WIDTH-1:0]    binario,
  output logic                ocupado,
  output logic                pronto,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int C_BCD_W = 4 * DIGITS;
  localparam int C_CNT_W = $clog2(WIDTH + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(WIDTH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [0:0] {
    OCIOSO   = 1'b0,
    CONVERTE = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_shift;
  logic [C_BCD_W-1:0]   r_acc;
  logic [C_CNT_W-1:0]   r_count;
  logic [C_BCD_W-1:0]   w_adj;
  logic [C_BCD_W-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_shift_next;

  // Every WIDTH-bit value must fit in DIGITS decimal digits (log10(2) ~ 0.30103).
  generate
    if (DIGITS * 100000 < WIDTH * 30103) begin : g_digits_check
      $error("conversor_binario_bcd: DIGITS too small for WIDTH");
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_nibble
      assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                           : r_acc[4*i +: 4];
    end
  endgenerate

  // Shift the adjusted accumulator and feed the binary MSB into the units LSB.
  assign w_acc_next   = (w_adj << 1) | C_BCD_W'(r_shift[WIDTH-1]);
  assign w_shift_next = r_shift << 1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= OCIOSO;
      r_shift <= '0;
      r_acc   <= '0;
      r_count <= '0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      bcd     <= '0;
    end else begin
      pronto <= 1'b0;
      case (r_state)
        OCIOSO: begin
          if (inicio) begin
            r_shift <= binario;
            r_acc   <= '0;
            r_count <= C_CNT_INIT;
            ocupado <= 1'b1;
            r_state <= CONVERTE;
          end
        end
        CONVERTE: begin
          r_acc   <= w_acc_next;
          r_shift <= w_shift_next;
          r_count <= r_count - C_CNT_ONE;
          // Only the finished accumulator ever reaches bcd.
          if (r_count == C_CNT_ONE) begin
            bcd     <= w_acc_next;
            pronto  <= 1'b1;
            ocupado <= 1'b0;
            r_state <= OCIOSO;
          end
        end
        default: begin
          r_state <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conversor_binario_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conversor_binario_bcd: scoreboard bench for conversor_binario_bcd.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conversor_binario_bcd;

  localparam int WIDTH   = 16;
  localparam int DIGITS  = 5;
  localparam int LAT     = WIDTH + 1;
  localparam int N_RAND  = 3000;

  logic                clock = 1'b0;
  logic                reset_n = 1'b1;
  logic                inicio = 1'b0;
  logic [WIDTH-1:0]    binario = '0;
  logic                ocupado;
  logic                pronto;
  logic [4*DIGITS-1:0] bcd;

  int checks = 0;
  int errors = 0;
  logic [4*DIGITS-1:0] exp_q[$];
  logic [4*DIGITS-1:0] last_exp = '0;
  bit hold_check = 1'b0;

  conversor_binario_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .inicio  (inicio),
    .binario (binario),
    .ocupado (ocupado),
    .pronto  (pronto),
    .bcd     (bcd)
  );

  always #5 clock = ~clock;

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] r;
    int x;
    x = int'(v);
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Output monitor: pops the scoreboard on pronto, otherwise bcd must hold.
  always @(negedge clock) begin
    if (reset_n) begin
      if (pronto) begin
        logic [4*DIGITS-1:0] e;
        bit bad;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pronto bcd=%h expected no pulse", bcd);
        end else begin
          e = exp_q.pop_front();
          if (bcd !== e) begin
            errors++;
            $display("FAIL result bcd=%h expected %h", bcd, e);
          end
          last_exp = e;
        end
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) if (bcd[4*d +: 4] > 4'd9) bad = 1'b1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL nibble_range bcd=%h expected all nibbles <= 9", bcd);
        end
      end else if (hold_check) begin
        checks++;
        if (bcd !== last_exp) begin
          errors++;
          $display("FAIL bcd_hold bcd=%h expected %h", bcd, last_exp);
        end
      end
    end
  end

  // Called at a negedge; counts negedges until pronto, starting from 'already'.
  task automatic wait_pronto(input int already, output int cyc);
    cyc = already;
    do begin
      @(negedge clock);
      cyc++;
    end while (!pronto && cyc < LAT + 10);
    if (!pronto) begin
      checks++;
      errors++;
      $display("FAIL timeout pronto=%b expected 1 within %0d cycles", pronto, LAT + 10);
    end
  endtask

  task automatic check_latency(input string name, input int cyc);
    checks++;
    if (cyc !== LAT) begin
      errors++;
      $display("FAIL %s_latency cycles=%0d expected %0d", name, cyc, LAT);
    end
  endtask

  // Called at a negedge with the DUT idle; one-cycle start pulse, then scrambles binario.
  task automatic start_pulse(input logic [WIDTH-1:0] v);
    inicio  = 1'b1;
    binario = v;
    exp_q.push_back(to_bcd(v));
    @(negedge clock);
    inicio  = 1'b0;
    binario = WIDTH'($urandom);
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || bcd !== '0) begin
      errors++;
      $display("FAIL reset_state ocupado=%b pronto=%b bcd=%h expected 0 0 00000",
               ocupado, pronto, bcd);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_first_edge_after_reset();
    int cyc;
    reset_n = 1'b1;
    hold_check = 1'b1;
    inicio  = 1'b1;
    binario = 16'd9999;
    exp_q.push_back(to_bcd(16'd9999));
    @(negedge clock);
    inicio = 1'b0;
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_accept ocupado=%b expected 1", ocupado);
    end
    wait_pronto(1, cyc);
    check_latency("first_edge", cyc);
    @(negedge clock);
  endtask

  task automatic test_zero();
    bit ok;
    inicio  = 1'b1;
    binario = '0;
    exp_q.push_back('0);
    ok = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clock);
      inicio = 1'b0;
      if (ocupado !== 1'b1 || pronto !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_busy_window ocupado=%b pronto=%b expected 1 0 for %0d cycles",
               ocupado, pronto, WIDTH);
    end
    @(negedge clock);
    checks++;
    if (pronto !== 1'b1 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL zero_done pronto=%b ocupado=%b expected 1 0", pronto, ocupado);
    end
    @(negedge clock);
    checks++;
    if (pronto !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_width pronto=%b expected 0", pronto);
    end
  endtask

  task automatic test_known_values();
    logic [WIDTH-1:0] vals [3];
    int cyc;
    vals[0] = 16'd65535;
    vals[1] = 16'd1234;
    vals[2] = 16'd10000;
    for (int k = 0; k < 3; k++) begin
      start_pulse(vals[k]);
      wait_pronto(1, cyc);
      check_latency("known", cyc);
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_pulse(16'd1234);
    wait_pronto(1, cyc);
    check_latency("b2b_first", cyc);
    inicio  = 1'b1;
    binario = 16'd4321;
    exp_q.push_back(to_bcd(16'd4321));
    @(negedge clock);
    inicio = 1'b0;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart pronto=%b ocupado=%b expected 0 1", pronto, ocupado);
    end
    wait_pronto(1, cyc);
    check_latency("b2b_second", cyc);
    @(negedge clock);
  endtask

  task automatic test_ignore_inicio();
    int cyc;
    int pulses;
    start_pulse(16'd500);
    repeat (4) @(negedge clock);
    inicio  = 1'b1;
    binario = 16'd7;
    @(negedge clock);
    inicio = 1'b0;
    wait_pronto(6, cyc);
    check_latency("ignore", cyc);
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      if (pronto || ocupado) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL ignore_no_queue activity_cycles=%0d expected 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int pulses;
    start_pulse(16'd12345);
    repeat (7) @(negedge clock);
    #2 reset_n = 1'b0;
    exp_q.delete();
    last_exp = '0;
    #1;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || bcd !== '0) begin
      errors++;
      $display("FAIL reset_mid_async ocupado=%b pronto=%b bcd=%h expected 0 0 00000",
               ocupado, pronto, bcd);
    end
    pulses = 0;
    repeat (WIDTH + 4) begin
      @(negedge clock);
      if (pronto) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_pronto pulses=%0d expected 0", pulses);
    end
    reset_n = 1'b1;
    start_pulse(16'd42);
    wait_pronto(1, cyc);
    check_latency("after_reset", cyc);
    @(negedge clock);
  endtask

  task automatic test_continuous_random();
    int cyc;
    logic [WIDTH-1:0] v;
    inicio  = 1'b1;
    binario = 16'd0;
    exp_q.push_back(to_bcd(16'd0));
    for (int n = 0; n < N_RAND; n++) begin
      wait_pronto(0, cyc);
      check_latency("continuous", cyc);
      if (n == N_RAND - 1) begin
        inicio = 1'b0;
      end else begin
        case (n)
          0:       v = 16'hFFFF;
          1:       v = 16'd9999;
          2:       v = 16'd1;
          default: v = WIDTH'($urandom);
        endcase
        binario = v;
        exp_q.push_back(to_bcd(v));
      end
    end
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() !== 0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL continuous_drain pending=%0d ocupado=%b expected 0 0",
               exp_q.size(), ocupado);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge_after_reset();
    test_zero();
    test_known_values();
    test_back_to_back();
    test_ignore_inicio();
    test_reset_mid();
    test_continuous_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
